// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the timer compare scheduler.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ARM  = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 64;

  // Ceiling log2, used for the scan pointer / winner index width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_sched_slot.sv
// One requester slot: valid bit plus absolute deadline, with accept/cancel/clear.
module timer_sched_slot
  import timer_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_deadline,
  input  logic             cancel,
  input  logic             clear,
  output logic             req_ready,
  output logic             valid,
  output logic [CNT_W-1:0] deadline
);

  // A cancel in the same cycle as a request blocks the handshake.
  assign req_ready = !valid && !cancel;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      deadline <= '0;
    end else if (cancel || clear) begin
      valid <= 1'b0;
    end else if (req_valid && req_ready) begin
      valid    <= 1'b1;
      deadline <= req_deadline;
    end
  end

endmodule

// File: rtl/timer_cmp_sched.sv
// Shares one timer compare among NUM_CH alarm channels: earliest deadline wins.
// Optional TIMER_SCHED_HALT_EN adds dbg_halt to freeze matching/rescans in WAIT.
module timer_cmp_sched
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef TIMER_SCHED_HALT_EN
  input  logic                    dbg_halt,
`endif
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*CNT_W-1:0] req_deadline,
  output logic [NUM_CH-1:0]       req_ready,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [CNT_W-1:0]        cnt_value,
  output logic [CNT_W-1:0]        cmp_value,
  output logic                    cmp_valid,
  output logic                    cmp_load,
  output logic [NUM_CH-1:0]       fire,
  output logic [NUM_CH-1:0]       pending,
  output logic                    busy
);

  localparam int IDX_W = clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t            state;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  run_win;
  logic [IDX_W-1:0]  win;
  logic [CNT_W-1:0]  run_min;
  logic              run_found;
  logic              dirty;

  logic [NUM_CH-1:0] slot_valid;
  logic [CNT_W-1:0]  slot_dl [NUM_CH];
  logic [NUM_CH-1:0] clear;
  logic [NUM_CH-1:0] accept;
  logic              halted;
  logic              cur_take;
  logic [CNT_W-1:0]  cur_dl;
  logic              match;
  logic              event_any;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    timer_sched_slot #(.CNT_W(CNT_W)) u_slot (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[g]),
      .req_deadline (req_deadline[g*CNT_W +: CNT_W]),
      .cancel       (cancel[g]),
      .clear        (clear[g]),
      .req_ready    (req_ready[g]),
      .valid        (slot_valid[g]),
      .deadline     (slot_dl[g])
    );
  end

`ifdef TIMER_SCHED_HALT_EN
  assign halted = dbg_halt;
`else
  assign halted = 1'b0;
`endif

  assign accept  = req_valid & req_ready;
  assign pending = slot_valid;
  assign busy    = (state != IDLE);

  always_comb begin
    cur_dl    = slot_dl[scan_idx];
    // Strict less-than while scanning upward gives ties to the lower index.
    cur_take  = slot_valid[scan_idx] && (!run_found || (cur_dl < run_min));
    event_any = (|accept) || (|cancel);
    // A cancel of the armed winner beats its match; a stale winner never fires.
    match     = (state == WAIT) && !halted && cmp_valid && (cnt_value >= cmp_value)
                && slot_valid[win] && !cancel[win];
    clear     = '0;
    if (match) clear = NUM_CH'(1) << win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scan_idx  <= '0;
      run_win   <= '0;
      run_min   <= '0;
      run_found <= 1'b0;
      win       <= '0;
      dirty     <= 1'b0;
      cmp_value <= '0;
      cmp_valid <= 1'b0;
      cmp_load  <= 1'b0;
      fire      <= '0;
    end else begin
      cmp_load <= 1'b0;
      fire     <= '0;
      case (state)
        IDLE: begin
          cmp_valid <= 1'b0;
          if (|slot_valid) begin
            state     <= SCAN;
            scan_idx  <= '0;
            run_found <= 1'b0;
            dirty     <= 1'b0;
          end
        end
        SCAN: begin
          // Changes behind the scan pointer force one more pass from WAIT.
          if (event_any) dirty <= 1'b1;
          if (cur_take) begin
            run_min   <= cur_dl;
            run_win   <= scan_idx;
            run_found <= 1'b1;
          end
          if (scan_idx == LAST_IDX) state <= (run_found || cur_take) ? ARM : IDLE;
          else scan_idx <= scan_idx + 1'b1;
        end
        ARM: begin
          if (event_any) dirty <= 1'b1;
          cmp_value <= run_min;
          cmp_valid <= 1'b1;
          cmp_load  <= 1'b1;
          win       <= run_win;
          state     <= WAIT;
        end
        WAIT: begin
          if (match) begin
            fire      <= clear;
            cmp_valid <= 1'b0;
            state     <= SCAN;
            scan_idx  <= '0;
            run_found <= 1'b0;
            dirty     <= 1'b0;
          end else if (halted) begin
            if (event_any) dirty <= 1'b1;
          end else if (event_any || dirty) begin
            cmp_valid <= 1'b0;
            state     <= SCAN;
            scan_idx  <= '0;
            run_found <= 1'b0;
            dirty     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cmp_sched.sv
// Directed bench for timer_cmp_sched; expected fire pulses go through a queue.
// Exercises dbg_halt when TIMER_SCHED_HALT_EN is defined.
module tb_timer_cmp_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 64;

  logic                    clk;
  logic                    rst;
`ifdef TIMER_SCHED_HALT_EN
  logic                    dbg_halt;
`endif
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*CNT_W-1:0] req_deadline;
  logic [NUM_CH-1:0]       req_ready;
  logic [NUM_CH-1:0]       cancel;
  logic [CNT_W-1:0]        cnt_value;
  logic [CNT_W-1:0]        cmp_value;
  logic                    cmp_valid;
  logic                    cmp_load;
  logic [NUM_CH-1:0]       fire;
  logic [NUM_CH-1:0]       pending;
  logic                    busy;

  int n_checks = 0;
  int n_err    = 0;
  logic [NUM_CH-1:0] exp_q[$];

  timer_cmp_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef TIMER_SCHED_HALT_EN
    .dbg_halt     (dbg_halt),
`endif
    .req_valid    (req_valid),
    .req_deadline (req_deadline),
    .req_ready    (req_ready),
    .cancel       (cancel),
    .cnt_value    (cnt_value),
    .cmp_value    (cmp_value),
    .cmp_valid    (cmp_valid),
    .cmp_load     (cmp_load),
    .fire         (fire),
    .pending      (pending),
    .busy         (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int ch, input logic [63:0] dl);
    req_valid[ch] = 1'b1;
    req_deadline[ch*CNT_W +: CNT_W] = dl;
    tick();
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_fires(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("fires_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every fire pulse must match the next expected one-hot.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] e;
    if (!rst && fire != '0) begin
      if (exp_q.size() == 0) begin
        check("fire_unexpected", 64'(fire), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("fire_order", 64'(fire), 64'(e));
      end
    end
  end

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_deadline = '0;
    cancel       = '0;
    cnt_value    = '0;
`ifdef TIMER_SCHED_HALT_EN
    dbg_halt     = 1'b0;
`endif
    ticks(2);
    check("rst_req_ready", 64'(req_ready), 64'hf);
    check("rst_cmp_value", cmp_value, 64'd0);
    check("rst_cmp_valid", 64'(cmp_valid), 64'd0);
    check("rst_cmp_load", 64'(cmp_load), 64'd0);
    check("rst_fire", 64'(fire), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // 1: single alarm, load latency and fire timing
    push(0, 64'd100);
    check("t1_pending", 64'(pending), 64'h1);
    check("t1_ready0_low", 64'(req_ready[0]), 64'd0);
    ticks(5);
    check("t1_no_load_early", 64'(cmp_load), 64'd0);
    tick();
    check("t1_cmp_load", 64'(cmp_load), 64'd1);
    check("t1_cmp_value", cmp_value, 64'd100);
    check("t1_cmp_valid", 64'(cmp_valid), 64'd1);
    tick();
    check("t1_load_pulse", 64'(cmp_load), 64'd0);
    cnt_value = 64'd99;
    tick();
    cnt_value = 64'd100;
    exp_q.push_back(4'b0001);
    tick();
    check("t1_fire_now", 64'(fire), 64'h1);
    wait_fires(5);
    ticks(8);
    check("t1_pending_clear", 64'(pending), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);

    // 2: ordering
    cnt_value = 64'd0;
    push(0, 64'd500);
    push(1, 64'd200);
    push(2, 64'd300);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    ticks(20);
    check("t2_cmp_value", cmp_value, 64'd200);
    check("t2_pending", 64'(pending), 64'h7);
    for (int c = 0; c <= 600; c += 10) begin
      cnt_value = 64'(c);
      tick();
    end
    wait_fires(20);
    ticks(8);
    check("t2_pending_clear", 64'(pending), 64'd0);

    // 3: tie with deadlines already passed
    cnt_value = 64'd80;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    push(3, 64'd50);
    push(1, 64'd50);
    wait_fires(40);
    ticks(8);
    check("t3_idle", 64'(busy), 64'd0);

    // 4: preempt by an earlier deadline
    cnt_value = 64'd0;
    push(0, 64'd1000);
    ticks(10);
    check("t4_cmp_first", cmp_value, 64'd1000);
    cnt_value = 64'd100;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    push(2, 64'd400);
    ticks(10);
    check("t4_cmp_preempt", cmp_value, 64'd400);
    for (int c = 100; c <= 1100; c += 20) begin
      cnt_value = 64'(c);
      tick();
    end
    wait_fires(20);
    ticks(8);

    // 5: cancel races the match
    cnt_value = 64'd0;
    push(1, 64'd300);
    ticks(10);
    check("t5_cmp_value", cmp_value, 64'd300);
    check("t5_cmp_valid", 64'(cmp_valid), 64'd1);
    cnt_value = 64'd300;
    cancel[1] = 1'b1;
    tick();
    cancel[1] = 1'b0;
    ticks(10);
    check("t5_pending", 64'(pending), 64'd0);
    check("t5_cmp_valid_off", 64'(cmp_valid), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);

    // cancel and request on the same channel: cancel blocks the handshake
    cancel[2]    = 1'b1;
    req_valid[2] = 1'b1;
    #1;
    check("cancel_blocks_ready", 64'(req_ready[2]), 64'd0);
    tick();
    cancel[2]    = 1'b0;
    req_valid[2] = 1'b0;
    check("cancel_no_store", 64'(pending), 64'd0);

`ifdef TIMER_SCHED_HALT_EN
    // 6: halt across the deadline, fire on release
    cnt_value = 64'd0;
    push(0, 64'd200);
    ticks(10);
    dbg_halt = 1'b1;
    for (int c = 150; c <= 250; c += 10) begin
      cnt_value = 64'(c);
      tick();
    end
    check("t6_held_pending", 64'(pending), 64'h1);
    check("t6_held_valid", 64'(cmp_valid), 64'd1);
    exp_q.push_back(4'b0001);
    dbg_halt = 1'b0;
    tick();
    check("t6_fire_release", 64'(fire), 64'h1);
    wait_fires(5);
    ticks(8);
`endif

    // reset mid-operation drops the slot without firing
    cnt_value = 64'd0;
    push(3, 64'd50);
    ticks(10);
    cnt_value = 64'd60;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_pending", 64'(pending), 64'd0);
    check("rst_mid_fire", 64'(fire), 64'd0);
    check("rst_mid_cmp_valid", 64'(cmp_valid), 64'd0);
    ticks(10);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
